ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 146 ++++++++++++++
 tb/tb_ifu_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding instruction-memory fetcher with
// a one-entry output slot, a one-entry skid slot and execute-stage redirect.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        out_ready_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_addr_q, skid_addr_d;
  logic        skid_valid_q, skid_valid_d;
  logic        drop_q, drop_d;
  logic        transfer;

  assign transfer     = out_valid_q & out_ready_i;
  assign imem_req_o   = (state_q == REQ) & ~jump_en_i;
  assign imem_addr_o  = pc_q;
  assign inst_o       = out_inst_q;
  assign inst_addr_o  = out_addr_q;
  assign inst_valid_o = out_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    out_inst_d   = out_inst_q;
    out_addr_d   = out_addr_q;
    out_valid_d  = out_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_addr_d  = skid_addr_q;
    skid_valid_d = skid_valid_q;
    drop_d       = drop_q;

    // Empty output slot always shows the bubble so outputs stay register-driven.
    if (transfer) begin
      out_valid_d = 1'b0;
      out_inst_d  = NOP_INST;
      out_addr_d  = '0;
    end

    if (jump_en_i) begin
      pc_d         = jump_addr_i & 32'hFFFF_FFFC;
      out_valid_d  = 1'b0;
      out_inst_d   = NOP_INST;
      out_addr_d   = '0;
      skid_valid_d = 1'b0;
      state_d      = REQ;
      // A response still in flight must be swallowed when it arrives.
      if (state_q == WAIT) begin
        if (imem_rvalid_i) begin
          drop_d = 1'b0;
        end else begin
          drop_d  = 1'b1;
          state_d = WAIT;
        end
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_gnt_i) begin
            req_addr_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else if (!out_valid_q || out_ready_i) begin
              out_inst_d  = imem_rdata_i;
              out_addr_d  = req_addr_q;
              out_valid_d = 1'b1;
              state_d     = REQ;
            end else begin
              skid_inst_d  = imem_rdata_i;
              skid_addr_d  = req_addr_q;
              skid_valid_d = 1'b1;
              state_d      = FULL;
            end
          end
        end
        FULL: begin
          if (transfer) begin
            out_inst_d   = skid_inst_q;
            out_addr_d   = skid_addr_q;
            out_valid_d  = skid_valid_q;
            skid_valid_d = 1'b0;
            state_d      = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= '0;
      out_inst_q   <= NOP_INST;
      out_addr_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_inst_q  <= NOP_INST;
      skid_addr_q  <= '0;
      skid_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      out_inst_q   <= out_inst_d;
      out_addr_q   <= out_addr_d;
      out_valid_q  <= out_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_addr_q  <= skid_addr_d;
      skid_valid_q <= skid_valid_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: a memory model answers requests, a monitor
// pops hand-computed expected fetches whenever an instruction transfers.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, jump_en, imem_req, imem_gnt, imem_rvalid, inst_valid, out_ready;
  logic [31:0] jump_addr, imem_addr, imem_rdata, inst, inst_addr;

  logic        rst2_n, req2, gnt2, rvalid2, valid2;
  logic [31:0] addr2, rdata2, inst2, inst_addr2;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .inst_o(inst), .inst_addr_o(inst_addr), .inst_valid_o(inst_valid),
    .out_ready_i(out_ready)
  );

  ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst2_n), .jump_en_i(1'b0), .jump_addr_i(32'h0),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(gnt2),
    .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
    .inst_o(inst2), .inst_addr_o(inst_addr2), .inst_valid_o(valid2),
    .out_ready_i(1'b1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory model: grants while budget lasts (after optional stall), responds rv_delay cycles later.
  int          budget = 0;
  int          stall = 0;
  int          rv_delay = 1;
  int          rv_cnt = 0;
  bit          pending = 1'b0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h1000_0001;
  endfunction

  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      if (!rst_n) begin
        pending = 1'b0;
      end else if (pending) begin
        if (rv_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pending     = 1'b0;
        end else begin
          rv_cnt--;
        end
      end else if (imem_req && budget > 0) begin
        if (stall > 0) begin
          stall--;
        end else begin
          imem_gnt  = 1'b1;
          pending   = 1'b1;
          pend_addr = imem_addr;
          rv_cnt    = rv_delay - 1;
          budget--;
        end
      end
    end
  end

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  int          xfer_cyc[$];
  int          cyc = 0;

  task automatic push(input logic [31:0] a, input logic [31:0] i);
    exp_addr_q.push_back(a);
    exp_inst_q.push_back(i);
  endtask

  initial begin
    logic [31:0] ea, ei;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (inst_valid && out_ready) begin
        if (exp_addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: got addr %h want none", inst_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          ei = exp_inst_q.pop_front();
          check("xfer_addr", inst_addr, ea);
          check("xfer_inst", inst, ei);
          xfer_cyc.push_back(cyc);
        end
      end else if (!inst_valid) begin
        check("idle_inst", inst, NOP);
        check("idle_addr", inst_addr, 32'h0);
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_addr_q.size() != 0 || pending || inst_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL %s_timeout: got %0d left want 0", name, exp_addr_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; jump_en = 1'b0; jump_addr = '0; out_ready = 1'b1;
    rst2_n = 1'b0; gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0;

    repeat (2) @(negedge clk);
    #3;
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, NOP);
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_pc", imem_addr, 32'h8000_0000);

    // Sequential fetch, one instruction every second cycle
    @(negedge clk);
    rst_n = 1'b1; budget = 3;
    push(32'h8000_0000, 32'h9000_0001);
    push(32'h8000_0004, 32'h9000_0005);
    push(32'h8000_0008, 32'h9000_0009);
    #3 check("idle_cycle_req", imem_req, 1'b0);
    wait_drain("seq");
    check("seq_count", 32'(xfer_cyc.size()), 32'd3);
    if (xfer_cyc.size() >= 3) begin
      check("seq_gap1", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd2);
      check("seq_gap2", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd2);
    end

    // Grant withheld five cycles
    budget = 1; stall = 5;
    push(32'h8000_000C, 32'h9000_000D);
    repeat (5) begin
      #3;
      check("stall_req", imem_req, 1'b1);
      check("stall_addr", imem_addr, 32'h8000_000C);
      @(negedge clk);
    end
    wait_drain("stall");

    // Downstream stalled: output + skid fill, no requests while full
    out_ready = 1'b0; budget = 3;
    push(32'h8000_0010, 32'h9000_0011);
    push(32'h8000_0014, 32'h9000_0015);
    push(32'h8000_0018, 32'h9000_0019);
    for (int i = 0; i < 6; i++) begin
      #3;
      if (i >= 4) begin
        check("full_req", imem_req, 1'b0);
        check("full_valid", inst_valid, 1'b1);
        check("full_addr", inst_addr, 32'h8000_0010);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_drain("skid");

    // Redirect while waiting; response arrives two cycles later and is dropped
    budget = 2; rv_delay = 3;
    push(32'h8000_0100, 32'h9000_0101);
    @(negedge clk);
    jump_en = 1'b1; jump_addr = 32'h8000_0102;
    #3 check("jmp_wait_req", imem_req, 1'b0);
    @(negedge clk);
    jump_en = 1'b0; rv_delay = 1;
    #3 check("jmp_pc", imem_addr, 32'h8000_0100);
    @(negedge clk);
    #3 check("jmp_drop_req", imem_req, 1'b0);
    @(negedge clk);
    #3 check("jmp_refetch_req", imem_req, 1'b1);
    check("jmp_refetch_addr", imem_addr, 32'h8000_0100);
    wait_drain("jmp_wait");

    // Redirect coincident with rvalid while the output slot is full
    out_ready = 1'b0; budget = 3;
    push(32'h8000_0200, 32'h9000_0201);
    @(negedge clk);
    @(negedge clk);
    #3 check("jfull_held", inst_addr, 32'h8000_0104);
    @(negedge clk);
    jump_en = 1'b1; jump_addr = 32'h8000_0200;
    #3 check("jfull_req", imem_req, 1'b0);
    @(negedge clk);
    jump_en = 1'b0; out_ready = 1'b1;
    #3 check("jfull_valid", inst_valid, 1'b0);
    check("jfull_req2", imem_req, 1'b1);
    check("jfull_addr", imem_addr, 32'h8000_0200);
    wait_drain("jmp_full");

    // Asynchronous reset in the middle of an outstanding fetch
    out_ready = 1'b0; budget = 2; rv_delay = 1;
    @(negedge clk);
    rv_delay = 3;
    @(negedge clk);
    @(negedge clk);
    #3 check("pre_rst_valid", inst_valid, 1'b1);
    #1 rst_n = 1'b0; budget = 0;
    #1;
    check("arst_valid", inst_valid, 1'b0);
    check("arst_inst", inst, NOP);
    check("arst_inst_addr", inst_addr, 32'h0);
    check("arst_pc", imem_addr, 32'h8000_0000);
    check("arst_req", imem_req, 1'b0);
    repeat (2) @(negedge clk);
    out_ready = 1'b1; rv_delay = 1; rst_n = 1'b1; budget = 1;
    push(32'h8000_0000, 32'h9000_0001);
    #3 check("rerst_idle_req", imem_req, 1'b0);
    @(negedge clk);
    #3 check("rerst_req", imem_req, 1'b1);
    check("rerst_addr", imem_addr, 32'h8000_0000);
    wait_drain("rerst");

    // PC wrap with RESET_PC = FFFF_FFFC on the second instance
    rst2_n = 1'b1;
    #3 check("wrap_idle_req", req2, 1'b0);
    @(negedge clk);
    gnt2 = 1'b1;
    #3 check("wrap_req0", req2, 1'b1);
    check("wrap_addr0", addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    gnt2 = 1'b0; rvalid2 = 1'b1; rdata2 = 32'hCAFE_0001;
    #3 check("wrap_wait_req", req2, 1'b0);
    @(negedge clk);
    rvalid2 = 1'b0; gnt2 = 1'b1;
    #3 check("wrap_out_valid0", valid2, 1'b1);
    check("wrap_out_inst0", inst2, 32'hCAFE_0001);
    check("wrap_out_addr0", inst_addr2, 32'hFFFF_FFFC);
    check("wrap_addr1", addr2, 32'h0000_0000);
    check("wrap_req1", req2, 1'b1);
    @(negedge clk);
    gnt2 = 1'b0; rvalid2 = 1'b1; rdata2 = 32'hCAFE_0002;
    #3 check("wrap_gap_valid", valid2, 1'b0);
    @(negedge clk);
    rvalid2 = 1'b0;
    #3 check("wrap_out_valid1", valid2, 1'b1);
    check("wrap_out_inst1", inst2, 32'hCAFE_0002);
    check("wrap_out_addr1", inst_addr2, 32'h0000_0000);

    check("queue_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
